// File: rtl/zemina90_port_writer_pkg.sv
// Shared definitions for the Zemina 90-in-1 bank register write side.
// Holds the commit FSM state encoding, the default port number and the port decode helper.
package zemina90_port_writer_pkg;

    typedef enum logic [1:0] {
        ZP_IDLE   = 2'd0,
        ZP_STROBE = 2'd1,
        ZP_COMMIT = 2'd2
    } zp_state_t;

    localparam logic [7:0] ZEMINA90_PORT      = 8'h77;
    localparam logic [7:0] ZEMINA90_RESET_VAL = 8'h00;

    // MSX I/O decodes only the low address byte.
    function automatic logic port_hit(input logic [7:0] addr_lo, input logic [7:0] port);
        return addr_lo == port;
    endfunction

endpackage

// File: rtl/zemina90_port_writer_io_strobe_capture.sv
// Port decode plus strobe-once capture: cap_vld pulses for one cycle on the first cycle of a write strobe.
// Latency 0 (combinational from the strobe); no backpressure, the owner must accept cap_vld when it fires.
module io_strobe_capture
    import zemina90_port_writer_pkg::*;
#(
    parameter logic [7:0] PORT_ADDR = ZEMINA90_PORT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] io_addr,
    input  logic       io_req,
    input  logic       io_wr,
    input  logic [7:0] wr_dat,
    output logic       wsel,
    output logic       cap_vld,
    output logic [7:0] cap_dat
);

    logic wsel_d;
    logic wsel_q;

    always_comb begin
        wsel   = enable & io_req & io_wr & port_hit(io_addr, PORT_ADDR);
        wsel_d = wsel;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wsel_q <= 1'b0;
        end else begin
            wsel_q <= wsel_d;
        end
    end

    // A strobe held over many cycles yields a single capture.
    assign cap_vld = wsel & ~wsel_q;
    assign cap_dat = wr_dat;

endmodule

// File: rtl/zemina90_port_writer.sv
// Zemina 90-in-1 bank register: captures OUT writes to the port, commits them only while cpu_mreq is low.
// Latency: commit on the first edge with a pending byte and cpu_mreq=0 (>=1 cycle after capture); no backpressure.
module zemina90_port_writer
    import zemina90_port_writer_pkg::*;
#(
    parameter logic [7:0] PORT_ADDR = ZEMINA90_PORT,
    parameter logic [7:0] RESET_VAL = ZEMINA90_RESET_VAL,
    parameter bit         READBACK  = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_iorq,
    input  logic        cpu_mreq,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    output logic [7:0]  data_to_mapper,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        commit
);

    zp_state_t  state_d, state_q;
    logic [7:0] pend_d, pend_q;
    logic       pending_d, pending_q;
    logic [7:0] bank_d, bank_q;
    logic       commit_d, commit_q;

    logic       wsel;
    logic       cap_vld;
    logic [7:0] cap_dat;
    logic       unused_addr_hi;

    assign unused_addr_hi = ^cpu_addr[15:8];

    io_strobe_capture #(
        .PORT_ADDR (PORT_ADDR)
    ) u_cap (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .io_addr (cpu_addr[7:0]),
        .io_req  (cpu_iorq),
        .io_wr   (cpu_wr),
        .wr_dat  (cpu_data_in),
        .wsel    (wsel),
        .cap_vld (cap_vld),
        .cap_dat (cap_dat)
    );

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        bank_d    = bank_q;
        commit_d  = 1'b0;

        if (!enable) begin
            state_d   = ZP_IDLE;
            pending_d = 1'b0;
            bank_d    = RESET_VAL;
        end else begin
            case (state_q)
                ZP_IDLE: begin
                    if (cap_vld) begin
                        pend_d    = cap_dat;
                        pending_d = 1'b1;
                        state_d   = ZP_STROBE;
                    end
                end
                ZP_STROBE: begin
                    // Commit need not wait for the strobe to end, only for a gap between memory cycles.
                    if (pending_q && !cpu_mreq) begin
                        bank_d    = pend_q;
                        pending_d = 1'b0;
                        commit_d  = 1'b1;
                    end
                    if (!wsel) begin
                        state_d = (pending_q && cpu_mreq) ? ZP_COMMIT : ZP_IDLE;
                    end
                end
                ZP_COMMIT: begin
                    // A fresh write supersedes the queued byte; the single commit carries the last value.
                    if (cap_vld) begin
                        pend_d  = cap_dat;
                        state_d = ZP_STROBE;
                    end else if (!cpu_mreq) begin
                        bank_d    = pend_q;
                        pending_d = 1'b0;
                        commit_d  = 1'b1;
                        state_d   = ZP_IDLE;
                    end
                end
                default: begin
                    state_d   = ZP_IDLE;
                    pending_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ZP_IDLE;
            pend_q    <= RESET_VAL;
            pending_q <= 1'b0;
            bank_q    <= RESET_VAL;
            commit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            bank_q    <= bank_d;
            commit_q  <= commit_d;
        end
    end

    assign data_to_mapper = bank_q;
    assign commit         = commit_q;
    assign data_oe        = READBACK & enable & cpu_iorq & cpu_rd & port_hit(cpu_addr[7:0], PORT_ADDR);
    assign data_out       = data_oe ? bank_q : 8'hFF;

endmodule

// File: tb/tb_zemina90_port_writer.sv
// Directed table-driven bench for the Zemina 90-in-1 port writer, with and without readback.
module tb_zemina90_port_writer;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_iorq;
    logic        cpu_mreq;
    logic        cpu_wr;
    logic        cpu_rd;

    logic [7:0]  bank_a, dout_a;
    logic        oe_a, commit_a;
    logic [7:0]  bank_b, dout_b;
    logic        oe_b, commit_b;

    int checks;
    int failures;

    zemina90_port_writer #(.READBACK(1'b1)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .cpu_addr       (cpu_addr),
        .cpu_data_in    (cpu_data_in),
        .cpu_iorq       (cpu_iorq),
        .cpu_mreq       (cpu_mreq),
        .cpu_wr         (cpu_wr),
        .cpu_rd         (cpu_rd),
        .data_to_mapper (bank_a),
        .data_out       (dout_a),
        .data_oe        (oe_a),
        .commit         (commit_a)
    );

    zemina90_port_writer #(.READBACK(1'b0)) dut_nrb (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .cpu_addr       (cpu_addr),
        .cpu_data_in    (cpu_data_in),
        .cpu_iorq       (cpu_iorq),
        .cpu_mreq       (cpu_mreq),
        .cpu_wr         (cpu_wr),
        .cpu_rd         (cpu_rd),
        .data_to_mapper (bank_b),
        .data_out       (dout_b),
        .data_oe        (oe_b),
        .commit         (commit_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        en;
        logic [15:0] addr;
        logic [7:0]  dat;
        logic        iorq;
        logic        mreq;
        logic        wr;
        logic        rd;
        logic [7:0]  e_bank;
        logic        e_commit;
        logic        e_oe;
        logic [7:0]  e_dout;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic [15:0] addr, input logic [7:0] dat,
                       input logic iorq, input logic mreq, input logic wr, input logic rd,
                       input logic [7:0] e_bank, input logic e_commit, input logic e_oe,
                       input logic [7:0] e_dout);
        vec_t v;
        v.en = en; v.addr = addr; v.dat = dat; v.iorq = iorq; v.mreq = mreq;
        v.wr = wr; v.rd = rd; v.e_bank = e_bank; v.e_commit = e_commit;
        v.e_oe = e_oe; v.e_dout = e_dout;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic en, input logic [15:0] addr, input logic [7:0] dat,
                         input logic iorq, input logic mreq, input logic wr, input logic rd);
        enable      = en;
        cpu_addr    = addr;
        cpu_data_in = dat;
        cpu_iorq    = iorq;
        cpu_mreq    = mreq;
        cpu_wr      = wr;
        cpu_rd      = rd;
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h expected=%h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Columns: en addr data iorq mreq wr rd | bank commit oe dout
        // Single write, strobe held 4 cycles, no memory cycle
        add(1, 16'h0000, 8'h00, 0, 0, 0, 0,  8'h00, 0, 0, 8'hFF);
        add(1, 16'h0077, 8'h85, 1, 0, 1, 0,  8'h00, 0, 0, 8'hFF);
        add(1, 16'h0077, 8'h85, 1, 0, 1, 0,  8'h85, 1, 0, 8'hFF);
        add(1, 16'h0077, 8'h85, 1, 0, 1, 0,  8'h85, 0, 0, 8'hFF);
        add(1, 16'h0077, 8'h11, 1, 0, 1, 0,  8'h85, 0, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 0, 0, 0,  8'h85, 0, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 0, 0, 0,  8'h85, 0, 0, 8'hFF);
        // Write during a 6-cycle memory cycle (iorq and mreq both high at first)
        add(1, 16'h0077, 8'hC3, 1, 1, 1, 0,  8'h85, 0, 0, 8'hFF);
        add(1, 16'h0077, 8'hC3, 1, 1, 1, 0,  8'h85, 0, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 1, 0, 0,  8'h85, 0, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 1, 0, 0,  8'h85, 0, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 1, 0, 0,  8'h85, 0, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 1, 0, 0,  8'h85, 0, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 0, 0, 0,  8'hC3, 1, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 0, 0, 0,  8'hC3, 0, 0, 8'hFF);
        // Back-to-back writes under mreq: last wins, one commit
        add(1, 16'h0077, 8'h10, 1, 1, 1, 0,  8'hC3, 0, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 1, 0, 0,  8'hC3, 0, 0, 8'hFF);
        add(1, 16'h0077, 8'h2A, 1, 1, 1, 0,  8'hC3, 0, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 1, 0, 0,  8'hC3, 0, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 0, 0, 0,  8'h2A, 1, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 0, 0, 0,  8'h2A, 0, 0, 8'hFF);
        // Same value rewritten still pulses commit
        add(1, 16'h0077, 8'h2A, 1, 0, 1, 0,  8'h2A, 0, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 0, 0, 0,  8'h2A, 1, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 0, 0, 0,  8'h2A, 0, 0, 8'hFF);
        // Port decode: 76h ignored, 177h accepted
        add(1, 16'h0076, 8'hFF, 1, 0, 1, 0,  8'h2A, 0, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 0, 0, 0,  8'h2A, 0, 0, 8'hFF);
        add(1, 16'h0177, 8'h5A, 1, 0, 1, 0,  8'h2A, 0, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 0, 0, 0,  8'h5A, 1, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 0, 0, 0,  8'h5A, 0, 0, 8'hFF);
        // Readback: committed value only
        add(1, 16'h0077, 8'h00, 1, 0, 0, 1,  8'h5A, 0, 1, 8'h5A);
        add(1, 16'h0076, 8'h00, 1, 0, 0, 1,  8'h5A, 0, 0, 8'hFF);
        add(1, 16'h0077, 8'h33, 1, 1, 1, 0,  8'h5A, 0, 0, 8'hFF);
        add(1, 16'h0077, 8'h00, 1, 1, 0, 1,  8'h5A, 0, 1, 8'h5A);
        add(1, 16'h0000, 8'h00, 0, 0, 0, 0,  8'h33, 1, 0, 8'hFF);
        // Enable dropped with a write pending
        add(1, 16'h0077, 8'h85, 1, 0, 1, 0,  8'h33, 0, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 0, 0, 0,  8'h85, 1, 0, 8'hFF);
        add(1, 16'h0077, 8'h44, 1, 1, 1, 0,  8'h85, 0, 0, 8'hFF);
        add(0, 16'h0000, 8'h00, 0, 1, 0, 0,  8'h00, 0, 0, 8'hFF);
        add(0, 16'h0077, 8'h00, 1, 0, 0, 1,  8'h00, 0, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 0, 0, 0,  8'h00, 0, 0, 8'hFF);
        add(1, 16'h0000, 8'h00, 0, 0, 0, 0,  8'h00, 0, 0, 8'hFF);

        reset_n = 1'b0;
        drive(1, 16'h0000, 8'h00, 0, 0, 0, 0);
        #12;
        chk("reset_bank", -1, bank_a, 8'h00);
        chk("reset_commit", -1, {7'd0, commit_a}, 8'h00);
        chk("reset_oe", -1, {7'd0, oe_a}, 8'h00);
        chk("reset_bank_nrb", -1, bank_b, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].addr, vecs[i].dat, vecs[i].iorq, vecs[i].mreq,
                  vecs[i].wr, vecs[i].rd);
            tick();
            chk("bank", i, bank_a, vecs[i].e_bank);
            chk("commit", i, {7'd0, commit_a}, {7'd0, vecs[i].e_commit});
            chk("data_oe", i, {7'd0, oe_a}, {7'd0, vecs[i].e_oe});
            chk("data_out", i, dout_a, vecs[i].e_dout);
            chk("nrb_bank", i, bank_b, vecs[i].e_bank);
            chk("nrb_commit", i, {7'd0, commit_b}, {7'd0, vecs[i].e_commit});
            chk("nrb_data_oe", i, {7'd0, oe_b}, 8'h00);
            chk("nrb_data_out", i, dout_b, 8'hFF);
        end

        // Asynchronous reset in the middle of a pending write
        drive(1, 16'h0077, 8'h9C, 1, 0, 1, 0);
        tick();
        drive(1, 16'h0000, 8'h00, 0, 0, 0, 0);
        tick();
        chk("pre_reset_bank", 100, bank_a, 8'h9C);
        drive(1, 16'h0077, 8'hA5, 1, 0, 1, 0);
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset_bank", 101, bank_a, 8'h00);
        chk("async_reset_commit", 101, {7'd0, commit_a}, 8'h00);
        chk("async_reset_oe", 101, {7'd0, oe_a}, 8'h00);
        chk("async_reset_bank_nrb", 101, bank_b, 8'h00);
        drive(1, 16'h0000, 8'h00, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("post_reset_bank", 102, bank_a, 8'h00);
        chk("post_reset_commit", 102, {7'd0, commit_a}, 8'h00);
        tick();
        chk("post_reset_bank2", 103, bank_a, 8'h00);
        chk("post_reset_commit2", 103, {7'd0, commit_a}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
